// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
//   Shared definitions for the 8:1 time-division multiplexer.
//   - state_t   : FSM encoding (IDLE, SEND, PARITY)
//   - NUM_LANES : lanes per frame (fixed at 8)
//   - SEL_W     : width of the slot index
//   - lane_xor  : reduces one bit column of a frame (bit b of every lane)
//                 to its parity; the top applies it per bit position to
//                 build the parity word.
// ---------------------------------------------------------------------------
package tdm_pkg;

    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        PARITY = 2'd2
    } state_t;

    // column[k] holds bit b of lane k; the result is bit b of the parity word
    function automatic logic lane_xor(input logic [NUM_LANES-1:0] column);
        return ^column;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// ---------------------------------------------------------------------------
// tdm_slot_counter
//   3-bit slot counter for the TDM multiplexer.
//   Ports:
//     clk   in   clock
//     rst   in   synchronous active-high reset (count -> 0)
//     en    in   advance by one (wraps 7 -> 0)
//     clr   in   force count to 0; overrides en
//     cnt   out  current slot index
//     last  out  high when cnt is the final lane (7)
// ---------------------------------------------------------------------------
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [SEL_W-1:0] cnt,
    output logic             last
);

    logic [SEL_W-1:0] cnt_reg;
    logic [SEL_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = cnt_reg + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt  = cnt_reg;
    assign last = (cnt_reg == SEL_W'(NUM_LANES - 1));

endmodule

// File: rtl/tdm_mux_8x1.sv
// ---------------------------------------------------------------------------
// tdm_mux_8x1
//   Time-division multiplexer: accepts one 8-lane frame per valid/ready
//   handshake and streams it one lane per cycle with a slot index, so a
//   downstream 1:8 demux can rebuild the frame.
//
//   Optional build macro: TDM_PARITY_EN
//     defined   : a 9th PARITY slot (XOR of all lanes, sel=7, parity_slot=1)
//                 follows slot 7; in_ready is raised there instead of slot 7.
//     undefined : plain 8-slot frames; parity_slot tied low.
//
//   Ports:
//     clk          in   clock
//     rst          in   synchronous active-high reset
//     in_valid     in   frame on din is valid
//     in_ready     out  frame can be accepted this cycle (combinational)
//     din          in   packed lanes, lane k = din[k*WIDTH +: WIDTH]
//     hold         in   stall: freeze slot counter and outputs
//     dout         out  current lane data
//     sel          out  current slot index
//     out_valid    out  dout/sel carry a valid slot
//     frame_sync   out  high on slot 0 of each frame
//     parity_slot  out  high on the parity slot
// ---------------------------------------------------------------------------
module tdm_mux_8x1
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_LANES*WIDTH-1:0] din,
    input  logic                       hold,
    output logic [WIDTH-1:0]           dout,
    output logic [SEL_W-1:0]           sel,
    output logic                       out_valid,
    output logic                       frame_sync,
    output logic                       parity_slot
);

    state_t                     state_reg, state_next;
    logic [NUM_LANES*WIDTH-1:0] frame_reg, frame_next;
    logic [WIDTH-1:0]           dout_reg, dout_next;
    logic [SEL_W-1:0]           sel_reg, sel_next;
    logic                       out_valid_reg, out_valid_next;
    logic                       frame_sync_reg, frame_sync_next;

    logic [SEL_W-1:0]           cnt;
    logic                       last;
    logic [SEL_W-1:0]           slot_inc;
    logic                       accept;
    logic [WIDTH-1:0]           frame_lane [NUM_LANES];

    // Unpack the latched frame into lanes for the slot mux
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign frame_lane[gi] = frame_reg[gi*WIDTH +: WIDTH];
    end

`ifdef TDM_PARITY_EN
    logic [WIDTH-1:0] parity_word;
    logic             parity_slot_reg, parity_slot_next;

    // Parity word built column by column: bit gi of every lane XORed together
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_par
        logic [NUM_LANES-1:0] column;
        always_comb begin
            column = '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                column[k] = frame_reg[k*WIDTH + gi];
            end
        end
        assign parity_word[gi] = lane_xor(column);
    end
`endif

    // The counter only steps while a data slot is on the outputs; it wraps
    // to 0 after slot 7, so it is already 0 when PARITY or IDLE is entered.
    tdm_slot_counter u_slot_counter (
        .clk  (clk),
        .rst  (rst),
        .en   ((state_reg == SEND) && !hold),
        .clr  (accept),
        .cnt  (cnt),
        .last (last)
    );

    assign slot_inc = cnt + SEL_W'(1);
    assign accept   = in_valid && in_ready;

    // Ready is raised on the final slot of a frame so the next frame's
    // slot 0 follows it directly with no bubble.
    always_comb begin
        in_ready = 1'b0;
        case (state_reg)
            IDLE:    in_ready = 1'b1;
`ifdef TDM_PARITY_EN
            SEND:    in_ready = 1'b0;
            PARITY:  in_ready = !hold;
`else
            SEND:    in_ready = last && !hold;
`endif
            default: in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        frame_next      = frame_reg;
        dout_next       = dout_reg;
        sel_next        = sel_reg;
        out_valid_next  = out_valid_reg;
        frame_sync_next = frame_sync_reg;
`ifdef TDM_PARITY_EN
        parity_slot_next = parity_slot_reg;
`endif
        if (accept) begin
            // Slot 0 comes straight from din so it appears the cycle after accept
            state_next      = SEND;
            frame_next      = din;
            dout_next       = din[WIDTH-1:0];
            sel_next        = '0;
            out_valid_next  = 1'b1;
            frame_sync_next = 1'b1;
`ifdef TDM_PARITY_EN
            parity_slot_next = 1'b0;
`endif
        end else if (!hold) begin
            case (state_reg)
                SEND: begin
                    if (!last) begin
                        dout_next       = frame_lane[slot_inc];
                        sel_next        = slot_inc;
                        out_valid_next  = 1'b1;
                        frame_sync_next = 1'b0;
                    end else begin
`ifdef TDM_PARITY_EN
                        state_next       = PARITY;
                        dout_next        = parity_word;
                        sel_next         = SEL_W'(NUM_LANES - 1);
                        out_valid_next   = 1'b1;
                        frame_sync_next  = 1'b0;
                        parity_slot_next = 1'b1;
`else
                        state_next      = IDLE;
                        dout_next       = '0;
                        sel_next        = '0;
                        out_valid_next  = 1'b0;
                        frame_sync_next = 1'b0;
`endif
                    end
                end
`ifdef TDM_PARITY_EN
                PARITY: begin
                    state_next       = IDLE;
                    dout_next        = '0;
                    sel_next         = '0;
                    out_valid_next   = 1'b0;
                    frame_sync_next  = 1'b0;
                    parity_slot_next = 1'b0;
                end
`endif
                default: begin
                    // IDLE outputs are already zero
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            frame_reg      <= '0;
            dout_reg       <= '0;
            sel_reg        <= '0;
            out_valid_reg  <= 1'b0;
            frame_sync_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            frame_reg      <= frame_next;
            dout_reg       <= dout_next;
            sel_reg        <= sel_next;
            out_valid_reg  <= out_valid_next;
            frame_sync_reg <= frame_sync_next;
        end
    end

`ifdef TDM_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_slot_reg <= 1'b0;
        end else begin
            parity_slot_reg <= parity_slot_next;
        end
    end
    assign parity_slot = parity_slot_reg;
`else
    assign parity_slot = 1'b0;
`endif

    assign dout       = dout_reg;
    assign sel        = sel_reg;
    assign out_valid  = out_valid_reg;
    assign frame_sync = frame_sync_reg;

endmodule

// File: tb/tb_tdm_mux_8x1.sv
// ---------------------------------------------------------------------------
// tb_tdm_mux_8x1
//   Scoreboard bench for tdm_mux_8x1. Every accepted frame pushes its
//   expected slots; each cycle the outputs are compared against the queue
//   head (or the frozen / idle / reset values). in_ready is predicted from
//   the scoreboard state each cycle. Honours TDM_PARITY_EN (WIDTH=4 then).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tdm_mux_8x1;

`ifdef TDM_PARITY_EN
    localparam int W = 4;
`else
    localparam int W = 1;
`endif
    localparam int NL = 8;
    localparam int VW = W + 6;   // {out_valid, frame_sync, parity_slot, sel, dout}

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [NL*W-1:0] din;
    logic            hold;
    logic [W-1:0]    dout;
    logic [2:0]      sel;
    logic            out_valid;
    logic            frame_sync;
    logic            parity_slot;

    int n_cmp = 0;
    int n_err = 0;

    logic [VW-1:0] exp_q [$];
    logic [VW-1:0] last_exp;
    bit            known = 0;

    tdm_mux_8x1 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .din         (din),
        .hold        (hold),
        .dout        (dout),
        .sel         (sel),
        .out_valid   (out_valid),
        .frame_sync  (frame_sync),
        .parity_slot (parity_slot)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] slot_vec(input logic ov, input logic ps,
                                               input logic [2:0] s, input logic [W-1:0] d);
        logic fs;
        fs = ov && (s == 3'd0) && !ps;
        return {ov, fs, ps, s, d};
    endfunction

    // Build a frame whose lane k is bit k of the pattern
    function automatic logic [NL*W-1:0] mk(input logic [7:0] bits);
        logic [NL*W-1:0] f;
        f = '0;
        for (int k = 0; k < NL; k++) f[k*W] = bits[k];
        return f;
    endfunction

    task automatic push_frame(input logic [NL*W-1:0] f);
        logic [W-1:0] px;
        px = '0;
        $display("accept frame din=%h", f);
        for (int k = 0; k < NL; k++) begin
            exp_q.push_back(slot_vec(1'b1, 1'b0, 3'(k), f[k*W +: W]));
            px ^= f[k*W +: W];
        end
`ifdef TDM_PARITY_EN
        exp_q.push_back(slot_vec(1'b1, 1'b1, 3'd7, px));
`endif
    endtask

    // One clock: check in_ready, note accept, clock, then check outputs
    task automatic tick(output bit acc);
        bit            r, hld, exp_rdy;
        logic [VW-1:0] obs;
        #1;
        exp_rdy = !last_exp[VW-1] || (exp_q.size() == 0 && !hold);
        if (known) check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        r   = rst;
        hld = hold;
        acc = in_valid && in_ready && !r;
        if (acc) push_frame(din);
        @(posedge clk);
        #1;
        obs = {out_valid, frame_sync, parity_slot, sel, dout};
        if (r) begin
            exp_q.delete();
            last_exp = '0;
            known = 1;
            check("reset", 32'(obs), 32'(last_exp));
        end else if (hld && !acc) begin
            check("held", 32'(obs), 32'(last_exp));
        end else if (exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            check("slot", 32'(obs), 32'(last_exp));
        end else begin
            last_exp = '0;
            check("idle", 32'(obs), 32'(last_exp));
        end
    endtask

    task automatic ticks(input int n);
        bit a;
        for (int i = 0; i < n; i++) tick(a);
    endtask

    initial begin
        bit            a;
        int            n_acc;
        logic [31:0]   r32;
        logic [NL*W-1:0] f6;

        last_exp = '0;
        rst = 1'b1; in_valid = 1'b0; hold = 1'b0; din = '0;
        ticks(2);
        rst = 1'b0;
        ticks(1);

        // 1: single frame
        din = mk(8'b1010_0110); in_valid = 1'b1;
        tick(a);
        check("t1_accept", {31'd0, a}, 32'd1);
        in_valid = 1'b0;
        ticks(11);

        // 2: two frames back to back, in_valid held
        n_acc = 0;
        din = mk(8'hFF); in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(a);
            if (a) begin
                n_acc++;
                din = mk(8'h00);
                if (n_acc == 2) in_valid = 1'b0;
            end
        end
        check("t2_accepts", 32'(n_acc), 32'd2);
        ticks(2);

        // 3: hold for 3 cycles at slot 4
        din = mk(8'b1100_1010); in_valid = 1'b1;
        tick(a);
        in_valid = 1'b0;
        ticks(4);
        hold = 1'b1;
        ticks(3);
        hold = 1'b0;
        ticks(7);

        // 4: reset mid-frame at slot 3, then a fresh frame
        din = mk(8'h5A); in_valid = 1'b1;
        tick(a);
        in_valid = 1'b0;
        ticks(3);
        rst = 1'b1;
        ticks(1);
        rst = 1'b0;
        ticks(1);
        din = mk(8'h3C); in_valid = 1'b1;
        tick(a);
        check("t4_accept", {31'd0, a}, 32'd1);
        in_valid = 1'b0;
        ticks(10);

        // 5: in_valid with different din while busy is ignored
        din = mk(8'h96); in_valid = 1'b1;
        tick(a);
        in_valid = 1'b0;
        ticks(2);
        din = mk(8'h69); in_valid = 1'b1;
        tick(a);
        check("t5_ignored", {31'd0, a}, 32'd0);
        in_valid = 1'b0;
        ticks(9);

        // accept while idle and held
        hold = 1'b1; din = mk(8'h81); in_valid = 1'b1;
        tick(a);
        check("idle_hold_accept", {31'd0, a}, 32'd1);
        in_valid = 1'b0; hold = 1'b0;
        ticks(10);

`ifdef TDM_PARITY_EN
        // 6: lanes 1..8, parity slot carries their XOR
        for (int k = 0; k < NL; k++) f6[k*W +: W] = W'(k + 1);
        din = f6; in_valid = 1'b1;
        tick(a);
        in_valid = 1'b0;
        ticks(10);
`endif

        // Random traffic with random stalls
        for (int i = 0; i < 300; i++) begin
            if (!in_valid) begin
                r32 = $urandom;
                din = r32[NL*W-1:0];
                in_valid = ($urandom_range(0, 2) != 0);
            end
            hold = ($urandom_range(0, 3) == 0);
            tick(a);
            if (a) in_valid = ($urandom_range(0, 1) == 1);
        end
        in_valid = 1'b0; hold = 1'b0;
        ticks(12);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
